// File: rtl/vec_pkg.sv
// Shared 4-lane x 8-bit SIMD layout: lanes sit in 12-bit slots of a 48-bit word.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package vec_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 8;
    localparam int SLOT_W = 12;
    localparam int WORD_W = 48;

    typedef logic [LANE_W-1:0] lane_t;
    typedef logic [SLOT_W-1:0] slot_t;
    typedef logic [WORD_W-1:0] word_t;

    // Place four lanes into their slots; the four pad bits above each lane are zero
    // so a per-slot subtract leaves the sign of the difference in the slot MSB.
    function automatic word_t pack4(input lane_t l0, input lane_t l1,
                                    input lane_t l2, input lane_t l3);
        return {4'h0, l3, 4'h0, l2, 4'h0, l1, 4'h0, l0};
    endfunction

    // Full 12-bit slot i of a packed word.
    function automatic slot_t get_slot(input word_t w, input int i);
        return w[i*SLOT_W +: SLOT_W];
    endfunction

    // Lane value (low 8 bits) carried in slot i of a packed word.
    function automatic lane_t unpack_slot(input word_t w, input int i);
        return w[i*SLOT_W +: LANE_W];
    endfunction

    // Sign bit of slot i; after a slot subtract this is the lane borrow.
    function automatic logic slot_sign(input word_t w, input int i);
        return w[i*SLOT_W + SLOT_W - 1];
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// Single valid/ready register stage of configurable data width.
// Latency: 1 cycle from input transfer to out_valid.
// Backpressure: accepts when empty or when the held word is taken this cycle; holds data while stalled.
module pipe_stage #(
    parameter int W = 48
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    // Room exists if nothing is held or the held word leaves on this edge.
    assign in_ready = ~out_valid | out_ready;

    // Register the word on an input transfer; clear valid when drained with no refill.
    always_ff @(posedge clock) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/vsub_const_pipe.sv
// Lane-wise subtract-constant on 4 x 8-bit lanes (FOUR12 slot layout), inverse of vadd_const.
// Latency: 2 cycles from input transfer to out_valid; 1 vector per cycle sustained.
// Backpressure: out_ready=0 freezes stage 2, stage 1 still fills once, then in_ready drops.
module vsub_const_pipe
    import vec_pkg::*;
#(
    parameter logic [7:0] C0    = 8'h02,
    parameter logic [7:0] C1    = 8'hFC,
    parameter logic [7:0] C2    = 8'h05,
    parameter logic [7:0] C3    = 8'hFD,
    parameter int         CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a_0,
    input  logic [7:0]       a_1,
    input  logic [7:0]       a_2,
    input  logic [7:0]       a_3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       y_0,
    output logic [7:0]       y_1,
    output logic [7:0]       y_2,
    output logic [7:0]       y_3,
    output logic [3:0]       borrow,
    output logic [CNT_W-1:0] count
);

    // Constants laid out in the same zero-padded slots as the operand.
    localparam word_t CWORD = pack4(C0, C1, C2, C3);

    word_t s1_din;
    word_t s1_dout;
    word_t s2_din;
    word_t s2_dout;
    logic  s1_in_ready;
    logic  s1_valid;
    logic  s2_in_ready;
    logic  s2_valid;
    logic  in_xfer;
    logic  unused_pad;

    assign s1_din = pack4(a_0, a_1, a_2, a_3);

    // Stage 1: packed operand word.
    pipe_stage #(
        .W(WORD_W)
    ) u_s1 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (s1_in_ready),
        .in_data   (s1_din),
        .out_valid (s1_valid),
        .out_ready (s2_in_ready),
        .out_data  (s1_dout)
    );

    // Independent 12-bit subtract per slot: no borrow crosses a slot boundary (FOUR12 Z-X).
    always_comb begin
        s2_din = '0;
        for (int i = 0; i < LANES; i++) begin
            s2_din[i*SLOT_W +: SLOT_W] = get_slot(s1_dout, i) - get_slot(CWORD, i);
        end
    end

    // Stage 2: per-slot difference, drives the outputs directly.
    pipe_stage #(
        .W(WORD_W)
    ) u_s2 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (s1_valid),
        .in_ready  (s2_in_ready),
        .in_data   (s2_din),
        .out_valid (s2_valid),
        .out_ready (out_ready),
        .out_data  (s2_dout)
    );

    // Held low while reset is asserted so nothing is offered a transfer that will be discarded.
    assign in_ready  = reset & s1_in_ready;
    assign in_xfer   = in_valid & in_ready;
    assign out_valid = s2_valid;

    assign y_0 = unpack_slot(s2_dout, 0);
    assign y_1 = unpack_slot(s2_dout, 1);
    assign y_2 = unpack_slot(s2_dout, 2);
    assign y_3 = unpack_slot(s2_dout, 3);

    // Borrow is the sign of each 12-bit slot difference.
    always_comb begin
        borrow = '0;
        for (int i = 0; i < LANES; i++) begin
            borrow[i] = slot_sign(s2_dout, i);
        end
    end

    // Slot bits 10:8 only replicate the sign and are not needed at the outputs.
    assign unused_pad = ^{s2_dout[46:44], s2_dout[34:32], s2_dout[22:20], s2_dout[10:8]};

    // Accepted-vector counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (in_xfer) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule
